// File: rtl/poly_sub_ctrl.sv
// poly_sub_ctrl
// Sequences one coefficient-wise modular subtraction c[i] = (a[i] - b[i]) mod q
// over a whole polynomial. It reads coefficient i from BRAM A and BRAM B, which
// share one read address. It feeds the registered subtractor and writes each
// result to the result BRAM. All arithmetic happens in the external subtractor.
// This block only sequences addresses and enables.
//
// Ports:
//   clk, rst_n            system clock (rising edge), async active-low reset
//   start                 one-cycle request to begin, honoured only in IDLE
//   hold                  pauses new reads; reads already issued still complete
//   busy                  high from the cycle after start through the done cycle
//   done                  one-cycle pulse once the last result has been written
//   rd_en, rd_addr        shared read port of BRAM A / BRAM B
//   rd_data_a, rd_data_b  BRAM read data (RD_LAT cycles after rd_en)
//   sub_a, sub_b          subtractor operands (pass-through of BRAM data)
//   sub_out               subtractor result (SUB_LAT cycles after operands)
//   wr_en, wr_addr        result BRAM write port
//   wr_data               write data (pass-through of sub_out)
module poly_sub_ctrl #(
    parameter int N_COEF  = 1024,
    parameter int ADDR_W  = 10,
    parameter int RD_LAT  = 1,
    parameter int SUB_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [23:0]       rd_data_a,
    input  logic [23:0]       rd_data_b,
    output logic [23:0]       sub_a,
    output logic [23:0]       sub_b,
    input  logic [23:0]       sub_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data
);

    localparam int PIPE_D = RD_LAT + SUB_LAT;

    // Selects every pipe stage except the last one. When those stages are empty,
    // the write happening now is the final one.
    localparam logic [PIPE_D-1:0] UPSTREAM_MASK = {1'b0, {(PIPE_D-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic              last_read;
    logic              pipe_empty_next;

    logic [PIPE_D-1:0] pipe_vld;
    logic [ADDR_W-1:0] pipe_addr [PIPE_D];

    // The data path is pure wiring. Operands and results pass through untouched.
    assign sub_a   = rd_data_a;
    assign sub_b   = rd_data_b;
    assign wr_data = sub_out;

    assign last_read       = (rd_cnt == ADDR_W'(N_COEF - 1));
    assign pipe_empty_next = ((pipe_vld & UPSTREAM_MASK) == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    // A read issues in every RUN cycle that hold is low.
    // DRAIN ignores hold and only waits for the tracking pipe to empty.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = !hold;
                if (!hold && last_read) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pipe_empty_next) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The read counter restarts from 0 for every run and advances once per issued read.
    // last_addr remembers the most recent issued address. rd_addr then stays stable
    // while no read is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt    <= '0;
            last_addr <= '0;
        end else begin
            if (state == IDLE) begin
                rd_cnt <= '0;
            end else if (rd_en) begin
                rd_cnt    <= rd_cnt + ADDR_W'(1);
                last_addr <= rd_cnt;
            end
        end
    end

    assign rd_addr = rd_en ? rd_cnt : last_addr;

    // The tracking pipe shifts a valid bit and an address alongside each read.
    // Its output lines up with the moment sub_out holds that coefficient's result.
    // Holes left by hold travel through the pipe as gaps in wr_en.
    // Reset flushes the pipe, so no write escapes after rst_n drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < PIPE_D; i++) begin
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= rd_en;
            pipe_addr[0] <= rd_addr;
            for (int i = 1; i < PIPE_D; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    assign wr_en   = pipe_vld[PIPE_D-1];
    assign wr_addr = pipe_addr[PIPE_D-1];

endmodule

// File: tb/tb_poly_sub_ctrl.sv
// Testbench for poly_sub_ctrl.
// It models the two coefficient BRAMs and the registered modular subtractor
// around an N_COEF=8 instance. The reference model derives read cycles, write
// cycles, results and the done cycle from the hold pattern. It places the expected
// writes in a scoreboard queue, and a monitor pops and compares them.
// A second instance with N_COEF=1 covers the single-coefficient edge case.
module tb_poly_sub_ctrl;

    localparam int N    = 8;
    localparam int AW   = 3;
    localparam int Q    = 12587009;
    localparam int MAXC = 64;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          hold  = 1'b0;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [23:0]   rd_data_a = '0;
    logic [23:0]   rd_data_b = '0;
    logic [23:0]   sub_out   = '0;
    logic [23:0]   sub_a, sub_b, wr_data;

    logic          start1 = 1'b0;
    logic          busy1, done1, rd_en1, wr_en1;
    logic [0:0]    rd_addr1, wr_addr1;
    logic [23:0]   rd_data_a1 = '0;
    logic [23:0]   rd_data_b1 = '0;
    logic [23:0]   sub_out1   = '0;
    logic [23:0]   sub_a1, sub_b1, wr_data1;

    poly_sub_ctrl #(.N_COEF(N), .ADDR_W(AW), .RD_LAT(1), .SUB_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .sub_a(sub_a), .sub_b(sub_b), .sub_out(sub_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    poly_sub_ctrl #(.N_COEF(1), .ADDR_W(1), .RD_LAT(1), .SUB_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .hold(1'b0),
        .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data_a(rd_data_a1), .rd_data_b(rd_data_b1),
        .sub_a(sub_a1), .sub_b(sub_b1), .sub_out(sub_out1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1)
    );

    logic [23:0] mem_a [N];
    logic [23:0] mem_b [N];

    // The environment provides 1-cycle BRAM reads and a 1-cycle registered
    // modular subtractor for both instances.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr];
            rd_data_b <= mem_b[rd_addr];
        end
        sub_out <= 24'((int'(sub_a) + Q - int'(sub_b)) % Q);
        if (rd_en1) begin
            rd_data_a1 <= 24'd3;
            rd_data_b1 <= 24'd3;
        end
        sub_out1 <= 24'((int'(sub_a1) + Q - int'(sub_b1)) % Q);
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   base   = 0;
    int   exp_done = 0;
    int   wr_count = 0;
    bit   done_seen = 1'b0;
    bit   active = 1'b0;
    bit   exp_rd [MAXC];
    int   exp_rd_addr [MAXC];
    exp_t sbq [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int refSub(input int a, input int b);
        return (a >= b) ? a - b : a - b + Q;
    endfunction

    // Monitor: samples on the falling edge, pops the scoreboard on each write
    // and checks the per-cycle busy, rd_en and done expectations.
    always @(negedge clk) begin
        int   rel;
        exp_t e;
        if (active) begin
            rel = cyc - base + 1;
            checkOutput("busy", int'(busy), int'(rel >= 1 && rel <= exp_done));
            checkOutput("done", int'(done), int'(rel == exp_done));
            checkOutput("rd_en", int'(rd_en), int'(exp_rd[rel]));
            if (rd_en && exp_rd[rel]) begin
                checkOutput("rd_addr", int'(rd_addr), exp_rd_addr[rel]);
            end
            if (wr_en) begin
                wr_count++;
                if (sbq.size() == 0) begin
                    checkOutput("unexpected write", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("wr_addr", int'(wr_addr), e.addr);
                    checkOutput("wr_data", int'(wr_data), e.data);
                    checkOutput("wr_cycle", rel, e.cyc);
                end
            end
            if (done) done_seen = 1'b1;
        end else begin
            checkOutput("idle wr_en", int'(wr_en), 0);
            checkOutput("idle done", int'(done), 0);
            checkOutput("idle busy", int'(busy), 0);
        end
    end

    // One run: the hold pattern determines the read cycles. Each write comes 2
    // cycles after its read, and done comes 3 cycles after the last read.
    // start_mask drives extra start pulses by cycle.
    // reset_at > 0 drops rst_n in that cycle.
    task automatic applyStimulus(input bit [MAXC-1:0] hold_mask,
                                 input bit [MAXC-1:0] start_mask,
                                 input int reset_at);
        int   c;
        exp_t e;
        sbq.delete();
        for (int k = 0; k < MAXC; k++) begin
            exp_rd[k]      = 1'b0;
            exp_rd_addr[k] = 0;
        end
        c = 1;
        for (int i = 0; i < N; i++) begin
            while (hold_mask[c]) c++;
            exp_rd[c]      = 1'b1;
            exp_rd_addr[c] = i;
            e.addr = i;
            e.data = refSub(int'(mem_a[i]), int'(mem_b[i]));
            e.cyc  = c + 2;
            sbq.push_back(e);
            c++;
        end
        exp_done = c + 2;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base      = cyc;
        wr_count  = 0;
        done_seen = 1'b0;
        active    = 1'b1;
        for (int k = 1; k <= exp_done + 2; k++) begin
            hold  = hold_mask[k];
            start = start_mask[k];
            if (k == reset_at) begin
                active = 1'b0;
                rst_n  = 1'b0;
                @(negedge clk);
                checkOutput("reset wr_en", int'(wr_en), 0);
                checkOutput("reset rd_en", int'(rd_en), 0);
                checkOutput("reset busy", int'(busy), 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                hold  = 1'b0;
                start = 1'b0;
                sbq.delete();
                return;
            end
            @(posedge clk);
            #1;
        end
        active = 1'b0;
        hold   = 1'b0;
        start  = 1'b0;
        checkOutput("write count", wr_count, N);
        checkOutput("scoreboard left", sbq.size(), 0);
        checkOutput("done seen", int'(done_seen), 1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        bit [MAXC-1:0] hm;
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 24'(100 + i);
            mem_b[i] = 24'd1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst busy", int'(busy), 0);
        checkOutput("rst done", int'(done), 0);
        checkOutput("rst rd_en", int'(rd_en), 0);
        checkOutput("rst wr_en", int'(wr_en), 0);
        checkOutput("rst rd_addr", int'(rd_addr), 0);
        checkOutput("rst wr_addr", int'(wr_addr), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] basic run");
        applyStimulus('0, '0, 0);

        $display("[TB] wrap-around");
        mem_a[0] = 24'd5;        mem_b[0] = 24'd7;
        mem_a[1] = 24'd0;        mem_b[1] = 24'd12587008;
        mem_a[2] = 24'd12587008; mem_b[2] = 24'd0;
        applyStimulus('0, '0, 0);

        $display("[TB] hold in cycles 3..5");
        hm = '0;
        hm[3] = 1'b1; hm[4] = 1'b1; hm[5] = 1'b1;
        applyStimulus(hm, '0, 0);

        $display("[TB] start while busy and in done cycle");
        hm = '0;
        hm[4]  = 1'b1;
        hm[11] = 1'b1;
        applyStimulus('0, hm, 0);

        $display("[TB] reset mid-run then fresh run");
        applyStimulus('0, '0, 5);
        repeat (2) @(posedge clk);
        applyStimulus('0, '0, 0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                mem_a[i] = 24'($urandom_range(Q - 1, 0));
                mem_b[i] = 24'($urandom_range(Q - 1, 0));
            end
            hm = '0;
            for (int c = 1; c <= 24; c++) begin
                if ($urandom_range(3, 0) == 0) hm[c] = 1'b1;
            end
            applyStimulus(hm, '0, 0);
        end

        $display("[TB] single coefficient instance");
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkOutput("n1 wr_en", int'(wr_en1), int'(k == 3));
            checkOutput("n1 done", int'(done1), int'(k == 4));
            checkOutput("n1 busy", int'(busy1), int'(k <= 4));
            if (k == 3) begin
                checkOutput("n1 wr_addr", int'(wr_addr1), 0);
                checkOutput("n1 wr_data", int'(wr_data1), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
